port_in_fifo: RTL and testbench
===============================

# port_in_fifo

Per-terminal ingress buffer of the mesh router node. It accepts packets from the attached link or terminal and presents the oldest stored packet, show-ahead, on `Data_out_i_in`/`pndng_i_in` to the node's bus interface. The bus interface consumes that packet by asserting its pop strobe. The block also provides full and almost-full backpressure to the producer, and counts packets dropped on overflow.

## Interface
- `pckg_sz`, 40, packet width in bits; `[pckg_sz-1:pckg_sz-8]` is the destination header.
- `Fif_Size`, 10, depth in packets; legal range 2..256.
- `af_lvl`, 8, almost-full threshold in packets; legal range 1..`Fif_Size`.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous reset, active-low.
- `Data_in`  input  `pckg_sz`  packet from the link or terminal.
- `push`  input  1  write strobe for `Data_in`.
- `pop`  input  1  consume the head packet; driven by the bus interface `Popin`.
- `Data_out_i_in`  output  `pckg_sz`  head packet; 0 when empty.
- `pndng_i_in`  output  1  FIFO non-empty.
- `full`  output  1  count == `Fif_Size`.
- `almost_full`  output  1  count >= `af_lvl`.
- `count`  output  `$clog2(Fif_Size+1)`  current occupancy.
- `drop_cnt`  output  16  packets discarded on overflow; saturates at 16'hFFFF.

## Operation
- Circular buffer of `Fif_Size` entries.
  - Write pointer `wr_ptr` and read pointer `rd_ptr`, each `$clog2(Fif_Size)` bits.
  - Occupancy register `count`.
- Each pointer wraps from `Fif_Size-1` to 0 explicitly. Power-of-two rollover is not relied upon.
- Accepted push: write `Data_in` to `mem[wr_ptr]` and advance `wr_ptr`.
- Accepted pop: advance `rd_ptr`.
- Acceptance rules:
  - A push is accepted when `count < Fif_Size`, or when `pop` is accepted in the same cycle.
  - A pop is accepted only when `count > 0`.
- Cycle outcomes:
  - Push only, accepted: `count` +1.
  - Pop only, accepted: `count` -1.
  - Push and pop both accepted: `count` unchanged.
- Push while full and no pop:
  - `Data_in` is discarded.
  - `drop_cnt` increments unless it is already 16'hFFFF.
  - Pointers and `count` are unchanged.
- Pop while empty is ignored. No state change and no error.
- Simultaneous push and pop at `count==0`: the pop is ignored and the push is accepted, so `count` becomes 1.
- `Data_out_i_in = pndng_i_in ? mem[rd_ptr] : 0`.
- `pndng_i_in`, `full` and `almost_full` are decoded from the `count` register. They are not decoded from pointer comparison.
- The header is not inspected. Routing is done downstream.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - `wr_ptr`, `rd_ptr`, `count` and `drop_cnt` to 0.
  - All outputs to 0: `Data_out_i_in`, `pndng_i_in`, `full`, `almost_full`, `count`, `drop_cnt`.
- Memory contents are not reset.
- Reset asserted mid-operation empties the FIFO immediately. A push or pop in the same cycle is lost.
- Latency:
  - A push accepted at edge N makes `pndng_i_in` and `Data_out_i_in` valid after edge N, i.e. in cycle N+1.
  - Pop at edge N: the next packet, or 0 if the FIFO is now empty, is presented after edge N.
  - The producer sees `full`/`almost_full` one cycle after the push that set them.
- Throughput: one push and one pop per cycle, sustained.
- `pop` is sampled only at the rising edge. The consumer must hold the captured `Data_out_i_in` itself, because the data changes after the pop edge.

## Structure
- Shared package `router_pkg`:
  - Header field positions `HDR_MSB` = `pckg_sz-1` and `HDR_LSB` = `pckg_sz-8`.
  - `DROP_W` = 16.
  - Helper function `ptr_inc(ptr, depth)` implementing the explicit wrap.
- One sub-module, `port_fifo_mem`:
  - Simple dual-port storage: one synchronous write port, one asynchronous read port.
  - Parameters `pckg_sz` and `Fif_Size`.
- Control, pointers and counters stay in `port_in_fifo`.

## Test plan
- Reset with `Fif_Size`=4: all outputs 0. Push 40'hAA_0000_0001 → next cycle `pndng_i_in`=1, `Data_out_i_in`=40'hAA_0000_0001, `count`=1.
- Push 4 distinct packets and no pops → `full`=1, `count`=4, `almost_full`=1 with `af_lvl`=3. Pops return the packets in push order. After the 4th pop `pndng_i_in`=0 and `Data_out_i_in`=0.
- Full FIFO, push 3 more with no pop → `drop_cnt`=3, contents unchanged. Preload `drop_cnt` to 16'hFFFE, then 5 more drops → `drop_cnt` stays 16'hFFFF.
- Full FIFO, push+pop in the same cycle for 10 cycles → `count` stays 4, `drop_cnt` stays 0, output order preserved across pointer wrap.
- Empty FIFO, push+pop in the same cycle → `count`=1 and the packet is presented. Pop on empty → no change.
- 3 packets stored, `rst` pulsed low mid-cycle → outputs 0 immediately. The first push after release appears at `Data_out_i_in` one cycle later.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the mesh router node: header field positions,
// drop-counter width, FIFO operation encoding and the explicit pointer wrap.
package router_pkg;

  localparam int unsigned PCKG_SZ_DEF = 40;
  localparam int unsigned HDR_MSB     = PCKG_SZ_DEF - 1;
  localparam int unsigned HDR_LSB     = PCKG_SZ_DEF - 8;
  localparam int unsigned DROP_W      = 16;

  // Accepted operations in one cycle, encoded as {push_ok, pop_ok}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Depths need not be powers of two, so the wrap is explicit
  function automatic logic [7:0] ptr_inc(input logic [7:0] ptr, input int unsigned depth);
    return (32'(ptr) == depth - 1) ? 8'd0 : ptr + 8'd1;
  endfunction

endpackage

// File: rtl/port_in_fifo_if.sv
// Producer/consumer bundle of the per-terminal ingress FIFO.
interface port_in_fifo_if #(
  parameter int unsigned pckg_sz  = 40,
  parameter int unsigned Fif_Size = 10
);
  import router_pkg::*;

  logic [pckg_sz-1:0]             Data_in;
  logic                           push;
  logic                           pop;
  logic [pckg_sz-1:0]             Data_out_i_in;
  logic                           pndng_i_in;
  logic                           full;
  logic                           almost_full;
  logic [$clog2(Fif_Size+1)-1:0]  count;
  logic [DROP_W-1:0]              drop_cnt;

  modport master (
    output Data_in, push, pop,
    input  Data_out_i_in, pndng_i_in, full, almost_full, count, drop_cnt
  );

  modport slave (
    input  Data_in, push, pop,
    output Data_out_i_in, pndng_i_in, full, almost_full, count, drop_cnt
  );

endinterface

// File: rtl/port_fifo_mem.sv
// Packet storage: one synchronous write port, one asynchronous read port.
module port_fifo_mem #(
  parameter int unsigned pckg_sz  = 40,
  parameter int unsigned Fif_Size = 10
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(Fif_Size)-1:0]  waddr,
  input  logic [pckg_sz-1:0]           wdata,
  input  logic [$clog2(Fif_Size)-1:0]  raddr,
  output logic [pckg_sz-1:0]           rdata
);

  logic [pckg_sz-1:0] mem [Fif_Size];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/port_in_fifo.sv
// Per-terminal ingress FIFO: show-ahead head packet, full/almost-full
// backpressure and a saturating overflow drop counter.
module port_in_fifo
  import router_pkg::*;
#(
  parameter int unsigned pckg_sz  = 40,
  parameter int unsigned Fif_Size = 10,
  parameter int unsigned af_lvl   = 8
) (
  input  logic          clk,
  input  logic          rst,
  port_in_fifo_if.slave bus
);

  localparam int unsigned PW = $clog2(Fif_Size);
  localparam int unsigned CW = $clog2(Fif_Size + 1);

  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      count_q, count_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               push_ok, pop_ok, drop;
  logic [pckg_sz-1:0] rdata;
  fifo_op_e           op;

  // Status is decoded from the occupancy register, never from pointers
  assign pop_ok  = bus.pop && (count_q != '0);
  assign push_ok = bus.push && ((count_q != CW'(Fif_Size)) || pop_ok);
  assign drop    = bus.push && !push_ok;
  assign op      = fifo_op_e'({push_ok, pop_ok});

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    drop_d  = drop_q;
    if (push_ok) wr_d = PW'(ptr_inc(8'(wr_q), Fif_Size));
    if (pop_ok)  rd_d = PW'(ptr_inc(8'(rd_q), Fif_Size));
    case (op)
      OP_PUSH: count_d = count_q + CW'(1);
      OP_POP:  count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  port_fifo_mem #(
    .pckg_sz  (pckg_sz),
    .Fif_Size (Fif_Size)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_q),
    .wdata (bus.Data_in),
    .raddr (rd_q),
    .rdata (rdata)
  );

  assign bus.pndng_i_in    = (count_q != '0);
  assign bus.Data_out_i_in = bus.pndng_i_in ? rdata : '0;
  assign bus.full          = (count_q == CW'(Fif_Size));
  assign bus.almost_full   = (count_q >= CW'(af_lvl));
  assign bus.count         = count_q;
  assign bus.drop_cnt      = drop_q;

endmodule

// File: tb/tb_port_in_fifo.sv
// Directed and randomized checks of port_in_fifo against a queue-based model.
module tb_port_in_fifo;

  localparam int PSZ   = 40;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [PSZ-1:0] mq[$];
  int unsigned    dm = 0;

  always #5 clk = ~clk;

  port_in_fifo_if #(.pckg_sz(PSZ), .Fif_Size(DEPTH)) bus ();

  port_in_fifo #(
    .pckg_sz  (PSZ),
    .Fif_Size (DEPTH),
    .af_lvl   (AF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, "/pndng"}, 64'(bus.pndng_i_in), 64'(n != 0));
    chk({tag, "/data"},  64'(bus.Data_out_i_in), (n != 0) ? 64'(mq[0]) : 64'd0);
    chk({tag, "/full"},  64'(bus.full), 64'(n == DEPTH));
    chk({tag, "/afull"}, 64'(bus.almost_full), 64'(n >= AF));
    chk({tag, "/count"}, 64'(bus.count), 64'(n));
    chk({tag, "/drop"},  64'(bus.drop_cnt), 64'(dm));
  endtask

  // One clock: drive at negedge, apply model rules at posedge, leave at next negedge
  task automatic cyc(input logic p, input logic o, input logic [PSZ-1:0] d);
    logic pop_acc, push_acc;
    bus.push    = p;
    bus.pop     = o;
    bus.Data_in = d;
    @(posedge clk);
    pop_acc  = o && (mq.size() > 0);
    push_acc = p && ((mq.size() < DEPTH) || pop_acc);
    if (pop_acc) void'(mq.pop_front());
    if (push_acc) mq.push_back(d);
    else if (p && dm < 32'hFFFF) dm++;
    @(negedge clk);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    mq.delete();
    dm = 0;
    chk_all("reset_hold");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] r;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.Data_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk_all("reset");
    rst = 1'b1;
    @(negedge clk);
    chk_all("released");

    // first push presented next cycle
    cyc(1'b1, 1'b0, 40'hAA_0000_0001);
    chk_all("push1");
    cyc(1'b0, 1'b1, '0);
    chk_all("pop1");

    // fill, then drain in order
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b0, {8'(8'hB0 + i), 32'(32'h1000 + i)});
      chk_all("fill");
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, '0);
      chk_all("drain");
    end

    // overflow drops with saturation
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b0, {8'(8'hC0 + i), 32'(32'h2000 + i)});
    end
    chk_all("full");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 40'hDE_ADBE_EF00 + 40'(i));
      chk_all("drop");
    end
    force dut.drop_q = 16'hFFFE;
    release dut.drop_q;
    dm = 32'hFFFE;
    #1;
    chk_all("preload");
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 40'hEE_0000_0000 + 40'(i));
      chk_all("drop_sat");
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, '0);
      chk_all("drain_after_drop");
    end

    @(negedge clk);
    do_reset();
    chk_all("reset2");

    // full FIFO, simultaneous push+pop across pointer wrap
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, {8'h11, 32'(i)});
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, {8'h22, 32'(i)});
      chk_all("full_pp");
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, '0);
      chk_all("drain_pp");
    end

    // empty FIFO: push+pop accepts the push; pop on empty ignored
    cyc(1'b1, 1'b1, 40'h33_1234_5678);
    chk_all("empty_pp");
    cyc(1'b0, 1'b1, '0);
    chk_all("pop_last");
    cyc(1'b0, 1'b1, '0);
    chk_all("pop_empty");

    // asynchronous reset mid-cycle with a pending push and pop
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, {8'h44, 32'(i)});
    chk_all("three");
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.push = 1'b1;
    bus.pop = 1'b1;
    bus.Data_in = 40'h55_5555_5555;
    #1;
    mq.delete();
    dm = 0;
    chk_all("async_rst");
    @(negedge clk);
    chk_all("async_rst_edge");
    bus.push = 1'b0;
    bus.pop = 1'b0;
    rst = 1'b1;
    cyc(1'b1, 1'b0, 40'h66_0000_0001);
    chk_all("post_rst_push");

    // randomized traffic: push-biased then pop-biased
    for (int i = 0; i < 400; i++) begin
      logic p, o;
      r = {$urandom(), $urandom()};
      if (i < 200) begin
        p = ($urandom_range(0, 3) != 0);
        o = ($urandom_range(0, 2) == 0);
      end else begin
        p = ($urandom_range(0, 2) == 0);
        o = ($urandom_range(0, 3) != 0);
      end
      cyc(p, o, r[PSZ-1:0]);
      chk_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
